// File: rtl/fpu_pkg.sv
// Shared FPU types and IEEE-754 single-precision constants.
package fpu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} sqrt_state_t;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_t;

  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
  localparam logic [31:0] FP_PZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NZERO = 32'h8000_0000;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

endpackage

// File: rtl/fp_classify.sv
// Combinational single-precision operand classifier (denormals fold into ZERO).
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] operand,
  output op_class_t   op_class,
  output logic        sign
);

  logic [7:0]  exp_field;
  logic [22:0] mant_field;

  assign sign       = operand[31];
  assign exp_field  = operand[30:23];
  assign mant_field = operand[22:0];

  always_comb begin
    op_class = NORM;
    if (exp_field == 8'h00) begin
      op_class = ZERO;
    end else if (exp_field == EXP_ALL1) begin
      op_class = (mant_field == 23'd0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/fpu_sqrt_issue.sv
// Issue/retire sequencer for the iterative sqrt core; specials are resolved locally.
// Optional core watchdog enabled by defining FPU_SQRT_TIMEOUT_EN.
module fpu_sqrt_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             cpu_clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_operand,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             kill,
  output logic             core_start,
  output logic [31:0]      core_operand,
  input  logic             core_done,
  input  logic [31:0]      core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_invalid
`ifdef FPU_SQRT_TIMEOUT_EN
  ,
  output logic             res_timeout
`endif
);

  sqrt_state_t state;
  op_class_t   op_class;
  logic        op_sign;
  logic        bypass;
  logic [31:0] bypass_data;
  logic        bypass_invalid;

`ifdef FPU_SQRT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] timeout_cnt;
`endif

  fp_classify u_classify (
    .operand  (req_operand),
    .op_class (op_class),
    .sign     (op_sign)
  );

  assign req_ready = (state == IDLE);

  // Only positive normals need the core; everything else has a closed-form answer.
  always_comb begin
    bypass         = 1'b1;
    bypass_data    = FP_PZERO;
    bypass_invalid = 1'b0;
    case (op_class)
      ZERO: bypass_data = op_sign ? FP_NZERO : FP_PZERO;
      INF: begin
        if (op_sign) begin
          bypass_data    = FP_QNAN;
          bypass_invalid = 1'b1;
        end else begin
          bypass_data = FP_PINF;
        end
      end
      NAN: begin
        bypass_data    = {req_operand[31:23], 1'b1, req_operand[21:0]};
        bypass_invalid = ~req_operand[22];
      end
      default: begin
        if (op_sign) begin
          bypass_data    = FP_QNAN;
          bypass_invalid = 1'b1;
        end else begin
          bypass = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      core_start   <= 1'b0;
      core_operand <= 32'd0;
      res_valid    <= 1'b0;
      res_data     <= 32'd0;
      res_tag      <= '0;
      res_invalid  <= 1'b0;
`ifdef FPU_SQRT_TIMEOUT_EN
      res_timeout  <= 1'b0;
      timeout_cnt  <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      if (kill) begin
        // Abort also blocks an accept in IDLE, so nothing changes there.
        if (state != IDLE) begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              res_tag <= req_tag;
`ifdef FPU_SQRT_TIMEOUT_EN
              res_timeout <= 1'b0;
`endif
              if (bypass) begin
                res_data    <= bypass_data;
                res_invalid <= bypass_invalid;
                res_valid   <= 1'b1;
                state       <= HOLD;
              end else begin
                core_operand <= req_operand;
                core_start   <= 1'b1;
                res_invalid  <= 1'b0;
                state        <= ISSUE;
              end
            end
          end
          ISSUE: begin
            state <= WAIT;
`ifdef FPU_SQRT_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
          WAIT: begin
            if (core_done) begin
              res_data  <= core_result;
              res_valid <= 1'b1;
              state     <= HOLD;
            end
`ifdef FPU_SQRT_TIMEOUT_EN
            else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_cnt <= timeout_cnt + 1'b1;
              res_data    <= FP_QNAN;
              res_invalid <= 1'b1;
              res_timeout <= 1'b1;
              res_valid   <= 1'b1;
              state       <= HOLD;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
`endif
          end
          HOLD: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_sqrt_issue.sv
// Directed self-checking bench for fpu_sqrt_issue (timeout cases need FPU_SQRT_TIMEOUT_EN).
module tb_fpu_sqrt_issue;

  localparam int TAG_W = 5;
`ifdef FPU_SQRT_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic             cpu_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_operand = 32'd0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             kill = 1'b0;
  logic             core_start;
  logic [31:0]      core_operand;
  logic             core_done = 1'b0;
  logic [31:0]      core_result = 32'd0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_invalid;
`ifdef FPU_SQRT_TIMEOUT_EN
  logic             res_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  fpu_sqrt_issue #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clk      (cpu_clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_operand  (req_operand),
    .req_tag      (req_tag),
    .kill         (kill),
    .core_start   (core_start),
    .core_operand (core_operand),
    .core_done    (core_done),
    .core_result  (core_result),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .res_invalid  (res_invalid)
`ifdef FPU_SQRT_TIMEOUT_EN
    ,
    .res_timeout  (res_timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic retire();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("retire_valid", {31'd0, res_valid}, 32'd0);
    check("retire_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Special operand: result one cycle after accept, core never started.
  task automatic do_special(input logic [31:0] op, input logic [TAG_W-1:0] tag,
                            input logic [31:0] exp_data, input logic exp_inv);
    req_valid = 1'b1; req_operand = op; req_tag = tag;
    tick();
    req_valid = 1'b0;
    $display("special op=%h tag=%0d -> data=%h inv=%0b", op, tag, res_data, res_invalid);
    check("sp_valid", {31'd0, res_valid}, 32'd1);
    check("sp_start", {31'd0, core_start}, 32'd0);
    check("sp_data", res_data, exp_data);
    check("sp_inv", {31'd0, res_invalid}, {31'd0, exp_inv});
    check("sp_tag", 32'(res_tag), 32'(tag));
    retire();
  endtask

  // Normal operand through the core with a directed core answer.
  task automatic do_normal(input logic [31:0] op, input logic [TAG_W-1:0] tag,
                           input logic [31:0] core_ans);
    req_valid = 1'b1; req_operand = op; req_tag = tag;
    tick();
    req_valid = 1'b0;
    check("nm_start", {31'd0, core_start}, 32'd1);
    check("nm_core_op", core_operand, op);
    check("nm_valid0", {31'd0, res_valid}, 32'd0);
    tick();
    check("nm_start_once", {31'd0, core_start}, 32'd0);
    core_done = 1'b1; core_result = core_ans;
    tick();
    core_done = 1'b0;
    $display("normal op=%h tag=%0d -> data=%h inv=%0b", op, tag, res_data, res_invalid);
    check("nm_valid", {31'd0, res_valid}, 32'd1);
    check("nm_data", res_data, core_ans);
    check("nm_tag", 32'(res_tag), 32'(tag));
    check("nm_inv", {31'd0, res_invalid}, 32'd0);
    retire();
  endtask

  initial begin
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_start", {31'd0, core_start}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_core_op", core_operand, 32'd0);
    check("rst_inv", {31'd0, res_invalid}, 32'd0);
`ifdef FPU_SQRT_TIMEOUT_EN
    check("rst_tmo", {31'd0, res_timeout}, 32'd0);
`endif
    @(negedge cpu_clk);
    reset_n = 1'b1;
    tick();

    do_normal(32'h4080_0000, 5'd3, 32'h4000_0000);
    do_special(32'h0000_0000, 5'd1, 32'h0000_0000, 1'b0);
    do_special(32'h8000_0000, 5'd2, 32'h8000_0000, 1'b0);
    do_special(32'h0000_0001, 5'd4, 32'h0000_0000, 1'b0);
    do_special(32'h8000_0001, 5'd5, 32'h8000_0000, 1'b0);
    do_special(32'hC040_0000, 5'd6, 32'h7FC0_0000, 1'b1);
    do_special(32'h7F80_0001, 5'd7, 32'h7FC0_0001, 1'b1);
    do_special(32'h7FC0_0005, 5'd8, 32'h7FC0_0005, 1'b0);
    do_special(32'h7F80_0000, 5'd9, 32'h7F80_0000, 1'b0);
    do_special(32'hFF80_0000, 5'd10, 32'h7FC0_0000, 1'b1);

    // Backpressure: result held, second request blocked until retire.
    req_valid = 1'b1; req_operand = 32'hC040_0000; req_tag = 5'd11;
    tick();
    req_operand = 32'h8000_0000; req_tag = 5'd12;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_data", res_data, 32'h7FC0_0000);
      check("hold_tag", 32'(res_tag), 32'd11);
      check("hold_inv", {31'd0, res_invalid}, 32'd1);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    $display("hold tag=11 data=%h held 5 cycles", res_data);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hold_idle", {31'd0, req_ready}, 32'd1);
    check("hold_drop", {31'd0, res_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    $display("re-accept op=80000000 tag=12 -> data=%h", res_data);
    check("reacc_valid", {31'd0, res_valid}, 32'd1);
    check("reacc_data", res_data, 32'h8000_0000);
    check("reacc_tag", 32'(res_tag), 32'd12);
    retire();

    // Kill in IDLE with a pending request: no accept.
    req_valid = 1'b1; req_operand = 32'h0000_0000; req_tag = 5'd13; kill = 1'b1;
    tick();
    kill = 1'b0; req_valid = 1'b0;
    $display("kill-in-idle ready=%0b valid=%0b", req_ready, res_valid);
    check("kidle_ready", {31'd0, req_ready}, 32'd1);
    check("kidle_valid", {31'd0, res_valid}, 32'd0);

    // Kill during WAIT; the stale core_done must be ignored.
    req_valid = 1'b1; req_operand = 32'h4080_0000; req_tag = 5'd14;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_idle", {31'd0, req_ready}, 32'd1);
    check("kill_valid", {31'd0, res_valid}, 32'd0);
    core_done = 1'b1; core_result = 32'h1234_5678;
    tick();
    core_done = 1'b0;
    $display("kill-in-wait stale done -> valid=%0b", res_valid);
    check("stale_done", {31'd0, res_valid}, 32'd0);
    tick();
    check("stale_done2", {31'd0, res_valid}, 32'd0);
    do_normal(32'h4110_0000, 5'd15, 32'h4040_0000);

    // Reset mid-WAIT returns everything to reset values at once.
    req_valid = 1'b1; req_operand = 32'h4080_0000; req_tag = 5'd16;
    tick();
    req_valid = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    $display("reset mid-wait ready=%0b data=%h", req_ready, res_data);
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_core_op", core_operand, 32'd0);
    check("mrst_data", res_data, 32'd0);
    check("mrst_tag", 32'(res_tag), 32'd0);
    check("mrst_valid", {31'd0, res_valid}, 32'd0);
    @(negedge cpu_clk);
    reset_n = 1'b1;
    tick();

`ifdef FPU_SQRT_TIMEOUT_EN
    // Withheld core_done: watchdog fires after 16 WAIT cycles.
    req_valid = 1'b1; req_operand = 32'h4080_0000; req_tag = 5'd17;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("tmo_early", {31'd0, res_valid}, 32'd0);
    tick();
    $display("timeout tag=17 -> data=%h tmo=%0b", res_data, res_timeout);
    check("tmo_valid", {31'd0, res_valid}, 32'd1);
    check("tmo_data", res_data, 32'h7FC0_0000);
    check("tmo_inv", {31'd0, res_invalid}, 32'd1);
    check("tmo_flag", {31'd0, res_timeout}, 32'd1);
    retire();
    do_special(32'h0000_0000, 5'd18, 32'h0000_0000, 1'b0);
    check("tmo_clear", {31'd0, res_timeout}, 32'd0);
    do_normal(32'h4080_0000, 5'd19, 32'h4000_0000);
    check("tmo_none", {31'd0, res_timeout}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sqrt_issue.md
Name: fpu_sqrt_issue

Overview:
- Issue/retire sequencer between the CPU FP decode stage and the iterative sqrt datapath.
- Accepts one single-precision operand per request (valid/ready) and classifies it.
- Special values (zero, denormal, negative, inf, NaN) bypass the core and are resolved locally; normal positive operands go to the core via a start/done handshake.
- Holds the result, with a tag and exception flag, until the writeback stage accepts it.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each request.
- TIMEOUT_CYCLES, 1024, cycles to wait for core_done before aborting (used only with the optional feature).

Ports:
- cpu_clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_operand  input  32  IEEE-754 single operand.
- req_tag  input  TAG_W  destination tag.
- kill  input  1  synchronous abort of the in-flight operation.
- core_start  output  1  one-cycle start pulse to the sqrt core.
- core_operand  output  32  registered operand to the core, stable from start until done.
- core_done  input  1  one-cycle pulse: core_result is valid.
- core_result  input  32  core output.
- res_valid  output  1  result available.
- res_ready  input  1  writeback accepts the result.
- res_data  output  32  result.
- res_tag  output  TAG_W  tag of the result.
- res_invalid  output  1  IEEE invalid-operation flag for this result.
- res_timeout  output  1  core timed out (present only with the optional feature).

Behaviour:
- Reset, asynchronous on reset_n low: state IDLE; req_ready=1; core_start=0; res_valid=0; core_operand, res_data, res_tag, res_invalid and res_timeout all 0; timeout counter 0.
- States: IDLE, ISSUE, WAIT, HOLD.
- Accept: a transfer occurs when req_valid && req_ready at a clock edge. On accept, latch operand and tag, then classify:
  - exp==0: zero or denormal; denormal is flushed to zero.
  - exp==FF and mant==0: infinity.
  - exp==FF and mant!=0: NaN.
  - otherwise: normal.
- IDLE transitions:
  - Special operand -> HOLD next cycle, res_valid=1 (accept-to-valid latency 1).
  - Normal positive operand -> ISSUE.
- Bypass results:
  - +0 or +denormal -> 0x00000000.
  - -0 or -denormal -> 0x80000000.
  - +inf -> 0x7F800000.
  - Any negative non-zero (including -inf) -> 0x7FC00000 with res_invalid=1.
  - NaN -> input with bit22 forced to 1; res_invalid=1 only if the input was a signalling NaN (bit22 was 0).
- ISSUE: core_start=1 for exactly one cycle; core_operand is already driven; go to WAIT.
- WAIT:
  - On core_done, capture core_result into res_data and go to HOLD; res_valid rises on the next cycle.
  - core_done in any other state is ignored.
- HOLD:
  - res_valid=1; res_data, res_tag and res_invalid stay stable until res_ready.
  - When res_valid && res_ready -> IDLE; res_valid=0 next cycle.
  - There is no same-cycle re-accept: req_ready is asserted only in IDLE. Back-to-back special requests therefore run one every 2 cycles.
- kill, synchronous, highest priority over all other events:
  - From ISSUE, WAIT or HOLD -> IDLE next cycle, with res_valid=0 and core_start=0.
  - A later core_done from the killed operation is ignored, because the state is not WAIT.
  - kill in IDLE while a request is valid: no accept occurs that cycle.
- reset_n falling mid-operation: immediate return to reset values; the core is expected to be reset by the same reset_n.
- No other width rules: data is 32-bit passthrough. Core semantics for 0 are never exercised, because zero always bypasses.

Optional Feature:
- FPU_SQRT_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without core_done: go to HOLD with res_data=0x7FC00000, res_invalid=1, res_timeout=1.
  - res_timeout is cleared on the next accept.
- Not defined: no counter, no res_timeout port; WAIT waits indefinitely.

Decomposition:
- Shared package fpu_pkg:
  - State enum.
  - Constants FP_QNAN=0x7FC00000, FP_PINF=0x7F800000, FP_PZERO, FP_NZERO, EXP_ALL1=8'hFF.
  - Operand class enum {ZERO, NORM, INF, NAN}.
- One natural sub-module: fp_classify, a combinational exponent/mantissa classifier reused by other FPU stages.

Test Plan:
- Accept 0x40800000 (4.0), tag 3 -> core_start pulses once with core_operand=0x40800000; core_done with 0x40000000 -> res_valid next cycle, res_data=0x40000000, res_tag=3, res_invalid=0.
- Accept 0x00000000, then 0x80000000 -> no core_start; res_data=0x00000000, then 0x80000000, each 1 cycle after accept; a denormal 0x00000001 gives 0x00000000.
- Accept 0xC0400000 (-3) -> res_data=0x7FC00000, res_invalid=1; accept 0x7F800001 (sNaN) -> 0x7FC00001, res_invalid=1.
- Hold res_ready=0 for 5 cycles in HOLD -> res_* stable, req_ready=0, a second req_valid is not accepted; raise res_ready -> IDLE, then accept.
- Assert kill during WAIT, then pulse core_done -> no res_valid; the next request 0x41100000 completes normally with the core returning 0x40400000.
- With FPU_SQRT_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold core_done -> after 16 WAIT cycles res_valid=1, res_data=0x7FC00000, res_timeout=1; also assert reset_n low mid-WAIT -> all outputs read reset values immediately.
